branch_unit: RTL and testbench

- Consumes the ALU's 2-bit compare flags and resolves control-flow opcodes (BEQ/BNE/BLT/BGT, CALL, RET, RETI) into registered PC redirects.
- Holds the architectural flag register, written by CMP results.
- Holds a hardware return-address stack (RAS) for CALL/RET/RETI.
- Sits beside the ALU in the execute stage and drives the fetch unit's redirect input.

---
 rtl/branch_unit.sv | 174 +++++++++++++++++
 tb/tb_branch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// branch_unit: resolves compare-driven branches, CALL/RET/RETI against a
// hardware return-address stack, and emits registered fetch redirects.
// Optional build macro BRU_ERR_EN adds a sticky ras_err output and turns
// overflow pushes into dropped pushes instead of circular overwrites.
module branch_unit #(
    parameter int          DEPTH   = 8,
    parameter int          PC_W    = 32,
    parameter int unsigned PC_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [4:0]      opcode,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    input  logic [1:0]      alu_flags,
    input  logic            flush,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [1:0]      flags_q,
`ifdef BRU_ERR_EN
    output logic            ras_err,
`endif
    output logic            reti_pulse,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [4:0] OP_CMP  = 5'b10010;
    localparam logic [4:0] OP_BEQ  = 5'b10100;
    localparam logic [4:0] OP_BNE  = 5'b10101;
    localparam logic [4:0] OP_BLT  = 5'b10110;
    localparam logic [4:0] OP_BGT  = 5'b10111;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_RET  = 5'b11010;
    localparam logic [4:0] OP_RETI = 5'b11011;

    // Stack storage; sp_q points at the next free slot, so the top is sp_q-1.
    // When full, sp_q also addresses the oldest entry.
    logic [PC_W-1:0] stack_mem [DEPTH];

    logic             redirect_q, redirect_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [1:0]       flags_d;
    logic             reti_pulse_q, reti_pulse_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BRU_ERR_EN
    logic             err_q, err_d;
`endif

    logic             qual;
    logic             empty_w;
    logic             full_w;
    logic             push_en;
    logic [PC_W-1:0]  push_data;
    logic [PTR_W-1:0] top_idx;
    logic [PC_W-1:0]  top_data;

    assign qual      = valid_in & ~flush;
    assign empty_w   = (cnt_q == '0);
    assign full_w    = (cnt_q == CNT_W'(DEPTH));
    assign push_data = pc + PC_W'(PC_STEP);
    assign top_idx   = sp_q - PTR_W'(1);
    assign top_data  = stack_mem[top_idx];

    // Decode the qualified instruction into next-state values for every flop.
    always_comb begin
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        reti_pulse_d  = 1'b0;
        flags_d       = flags_q;
        sp_d          = sp_q;
        cnt_d         = cnt_q;
        push_en       = 1'b0;
`ifdef BRU_ERR_EN
        err_d         = err_q;
`endif
        if (qual) begin
            case (opcode)
                OP_CMP: flags_d = alu_flags;
                OP_BEQ, OP_BNE, OP_BLT, OP_BGT: begin
                    // Conditions read the architectural flags, never alu_flags.
                    unique case (opcode)
                        OP_BEQ:  redirect_d = flags_q[0];
                        OP_BNE:  redirect_d = ~flags_q[0];
                        OP_BLT:  redirect_d = flags_q[1];
                        default: redirect_d = ~flags_q[0] & ~flags_q[1];
                    endcase
                    if (redirect_d) begin
                        redirect_pc_d = target;
                    end
                end
                OP_CALL: begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = target;
                    if (!full_w) begin
                        push_en = 1'b1;
                        sp_d    = sp_q + PTR_W'(1);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
`ifdef BRU_ERR_EN
                        // Overflow: keep the stack intact and flag the error.
                        err_d   = 1'b1;
`else
                        // Overflow: overwrite the oldest entry, count stays full.
                        push_en = 1'b1;
                        sp_d    = sp_q + PTR_W'(1);
`endif
                    end
                end
                OP_RET, OP_RETI: begin
                    if (!empty_w) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = top_data;
                        reti_pulse_d  = (opcode == OP_RETI);
                        sp_d          = top_idx;
                        cnt_d         = cnt_q - CNT_W'(1);
                    end else begin
`ifdef BRU_ERR_EN
                        err_d = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            reti_pulse_q  <= 1'b0;
            flags_q       <= 2'b00;
            sp_q          <= '0;
            cnt_q         <= '0;
`ifdef BRU_ERR_EN
            err_q         <= 1'b0;
`endif
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            reti_pulse_q  <= reti_pulse_d;
            flags_q       <= flags_d;
            sp_q          <= sp_d;
            cnt_q         <= cnt_d;
`ifdef BRU_ERR_EN
            err_q         <= err_d;
`endif
        end
    end

    // Stack write port; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            stack_mem[sp_q] <= push_data;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign reti_pulse  = reti_pulse_q;
    assign ras_empty   = empty_w;
    assign ras_full    = full_w;
`ifdef BRU_ERR_EN
    assign ras_err     = err_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed vectors with hand-computed expectations for branch_unit.
module tb_branch_unit;

    localparam logic [4:0] OP_CMP  = 5'b10010;
    localparam logic [4:0] OP_BEQ  = 5'b10100;
    localparam logic [4:0] OP_BNE  = 5'b10101;
    localparam logic [4:0] OP_BLT  = 5'b10110;
    localparam logic [4:0] OP_BGT  = 5'b10111;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_RET  = 5'b11010;
    localparam logic [4:0] OP_RETI = 5'b11011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [4:0]  opcode = 5'b0;
    logic [31:0] pc = '0;
    logic [31:0] target = '0;
    logic [1:0]  alu_flags = 2'b00;
    logic        flush = 1'b0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  flags_q;
    logic        reti_pulse;
    logic        ras_empty;
    logic        ras_full;
`ifdef BRU_ERR_EN
    logic        ras_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    branch_unit #(.DEPTH(8), .PC_W(32), .PC_STEP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .opcode     (opcode),
        .pc         (pc),
        .target     (target),
        .alu_flags  (alu_flags),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .flags_q    (flags_q),
`ifdef BRU_ERR_EN
        .ras_err    (ras_err),
`endif
        .reti_pulse (reti_pulse),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for one cycle, then sample 1 ns after the edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] p, input logic [31:0] t,
                         input logic [1:0] f, input logic fl);
        @(negedge clk);
        valid_in  = 1'b1;
        opcode    = op;
        pc        = p;
        target    = t;
        alu_flags = f;
        flush     = fl;
        @(posedge clk);
        #1;
        $display("txn op=%b pc=%h tgt=%h fl=%b -> redirect=%b rpc=%h reti=%b flags=%b empty=%b full=%b",
                 op, p, t, fl, redirect, redirect_pc, reti_pulse, flags_q, ras_empty, ras_full);
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        $display("txn idle -> redirect=%b reti=%b", redirect, reti_pulse);
    endtask

    logic [31:0] ra_tab [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst is held.
        #2;
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_flags", 32'(flags_q), 32'd0);
        chk("rst_reti", 32'(reti_pulse), 32'd0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_full", 32'(ras_full), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Flags and conditional branches.
        issue(OP_CMP, 32'h0, 32'h0, 2'b01, 1'b0);
        chk("cmp01_flags", 32'(flags_q), 32'd1);
        chk("cmp_no_redirect", 32'(redirect), 32'd0);
        issue(OP_BEQ, 32'h4, 32'h40, 2'b10, 1'b0);
        chk("beq_taken", 32'(redirect), 32'd1);
        chk("beq_pc", redirect_pc, 32'h40);
        chk("beq_flags_kept", 32'(flags_q), 32'd1);
        issue(OP_BNE, 32'h8, 32'h44, 2'b00, 1'b0);
        chk("bne_not_taken", 32'(redirect), 32'd0);
        issue(OP_CMP, 32'h0, 32'h0, 2'b10, 1'b0);
        issue(OP_BLT, 32'hc, 32'h80, 2'b00, 1'b0);
        chk("blt_taken", 32'(redirect), 32'd1);
        chk("blt_pc", redirect_pc, 32'h80);
        issue(OP_BGT, 32'h10, 32'h84, 2'b00, 1'b0);
        chk("bgt_not_taken_n", 32'(redirect), 32'd0);
        issue(OP_CMP, 32'h0, 32'h0, 2'b00, 1'b0);
        issue(OP_BGT, 32'h14, 32'h90, 2'b11, 1'b0);
        chk("bgt_taken", 32'(redirect), 32'd1);
        chk("bgt_pc", redirect_pc, 32'h90);
        issue(OP_BEQ, 32'h18, 32'h94, 2'b01, 1'b0);
        chk("beq_not_taken", 32'(redirect), 32'd0);

        // Nested CALL / RET.
        issue(OP_CALL, 32'h10, 32'h100, 2'b00, 1'b0);
        chk("call1_redirect", 32'(redirect), 32'd1);
        chk("call1_pc", redirect_pc, 32'h100);
        chk("call1_nonempty", 32'(ras_empty), 32'd0);
        issue(OP_CALL, 32'h104, 32'h200, 2'b00, 1'b0);
        chk("call2_pc", redirect_pc, 32'h200);
        issue(OP_RET, 32'h200, 32'h0, 2'b00, 1'b0);
        chk("ret1_redirect", 32'(redirect), 32'd1);
        chk("ret1_pc", redirect_pc, 32'h105);
        issue(OP_RET, 32'h108, 32'h0, 2'b00, 1'b0);
        chk("ret2_pc", redirect_pc, 32'h11);
        chk("ret2_empty", 32'(ras_empty), 32'd1);

        // RETI on empty stack.
        issue(OP_RETI, 32'h30, 32'h0, 2'b00, 1'b0);
        chk("reti_empty_redirect", 32'(redirect), 32'd0);
        chk("reti_empty_pulse", 32'(reti_pulse), 32'd0);
        chk("reti_empty_still", 32'(ras_empty), 32'd1);
`ifdef BRU_ERR_EN
        chk("reti_empty_err", 32'(ras_err), 32'd1);
`endif

        // Flush suppresses both branches and flag writes.
        issue(OP_CMP, 32'h0, 32'h0, 2'b01, 1'b0);
        issue(OP_CMP, 32'h0, 32'h0, 2'b10, 1'b1);
        chk("flush_cmp_flags", 32'(flags_q), 32'd1);
        issue(OP_BEQ, 32'h34, 32'h60, 2'b00, 1'b1);
        chk("flush_beq", 32'(redirect), 32'd0);

        // RETI after CALL.
        issue(OP_CALL, 32'h20, 32'h300, 2'b00, 1'b0);
        issue(OP_RETI, 32'h300, 32'h0, 2'b00, 1'b0);
        chk("reti_redirect", 32'(redirect), 32'd1);
        chk("reti_pc", redirect_pc, 32'h21);
        chk("reti_pulse", 32'(reti_pulse), 32'd1);
        idle();
        chk("pulse_clear_redirect", 32'(redirect), 32'd0);
        chk("pulse_clear_reti", 32'(reti_pulse), 32'd0);

        // Nine CALLs into an eight-entry stack.
        for (int i = 0; i < 9; i++) begin
            ra_tab[i] = 32'h1000 + 32'(i) * 32'd4 + 32'd1;
            issue(OP_CALL, 32'h1000 + 32'(i) * 32'd4, 32'h2000 + 32'(i), 2'b00, 1'b0);
            chk("ovf_call_redirect", 32'(redirect), 32'd1);
            if (i == 7) chk("full_after_8", 32'(ras_full), 32'd1);
        end
        chk("full_after_9", 32'(ras_full), 32'd1);
`ifdef BRU_ERR_EN
        chk("ovf_err", 32'(ras_err), 32'd1);
        for (int k = 0; k < 8; k++) begin
            issue(OP_RET, 32'h3000, 32'h0, 2'b00, 1'b0);
            chk("ovf_ret_pc", redirect_pc, ra_tab[7 - k]);
        end
`else
        for (int k = 0; k < 8; k++) begin
            issue(OP_RET, 32'h3000, 32'h0, 2'b00, 1'b0);
            chk("ovf_ret_pc", redirect_pc, ra_tab[8 - k]);
        end
`endif
        chk("ovf_drain_empty", 32'(ras_empty), 32'd1);

        // Asynchronous reset in the middle of a redirect pulse.
        issue(OP_CALL, 32'h50, 32'h500, 2'b00, 1'b0);
        chk("pre_rst_redirect", 32'(redirect), 32'd1);
        chk("pre_rst_flags", 32'(flags_q), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_redirect", 32'(redirect), 32'd0);
        chk("async_rst_empty", 32'(ras_empty), 32'd1);
        chk("async_rst_flags", 32'(flags_q), 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b0;
        idle();
        chk("post_rst_redirect", 32'(redirect), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
